if_prefetch: RTL and testbench
==============================

// Module: if_prefetch
// PURPOSE
//  Decoupled instruction-fetch front end; successor to the single-cycle fetch path (direct inst_addr/inst_ena).
//  Issues sequential fetches to instruction memory over a valid/ready request channel with variable-latency, in-order responses.
//  Buffers up to DEPTH instructions, each tagged with its PC, and presents them to decode through a valid/ready handshake.
//  Supports redirect (branch/jump/trap) with flush of buffered and in-flight fetches.
// PARAMETERS
//  XLEN      64                   address/PC width (matches `REG_BUS)
//  DEPTH     4                    queue slots and max in-flight requests; power of 2, >=2
//  RESET_PC  64'h0000_0000_8000_0000  first fetch address after reset
// PORTS
//  clk             in   1     clock
//  rst             in   1     asynchronous reset, active-low (asserted at 0)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address, 4-byte aligned
//  imem_rsp_valid  in   1     response valid; responses return in request order, latency >=1 cycle
//  imem_rsp_data   in   32    fetched instruction
//  redirect_valid  in   1     flush and restart fetch
//  redirect_pc     in   XLEN  new fetch PC; bits [1:0] ignored (forced 0)
//  inst_valid      out  1     instruction available to decode
//  inst_ready      in   1     decode consumes instruction
//  inst_out        out  32    instruction
//  inst_pc         out  XLEN  PC of inst_out
// BEHAVIOUR
//  Reset (rst=0, async): fetch_pc=RESET_PC; alloc/fill/read pointers, occupancy, drop_cnt = 0; imem_req_valid=0; inst_valid=0.
//  Credits: request allowed when occ + drop_cnt < DEPTH, where occ = allocated slots (filled or not).
//  Request: imem_req_valid=1 whenever a credit exists and rst=1; imem_req_addr=fetch_pc.
//   Fire (valid&ready): allocate slot at alloc ptr with pc=fetch_pc, filled=0; fetch_pc += 4 (wraps mod 2^XLEN).
//   Once asserted, valid and addr are held until fire, except on redirect (addr may change to redirect_pc next cycle).
//  Response: if drop_cnt>0, discard and drop_cnt-=1; else write data to fill-ptr slot, set filled, fill ptr++.
//   imem_rsp_valid with no outstanding request is a protocol error (bench assertion); the DUT ignores it.
//  Output: head slot filled -> inst_valid=1, inst_out/inst_pc from head; fire on inst_valid&inst_ready frees slot.
//   inst_valid is forced 0 in any cycle redirect_valid=1, so no consume occurs in a redirect cycle.
//   Latency: response at cycle N -> inst_valid at N+1 (registered, no bypass).
//   Throughput: 1 inst/cycle sustained with 1-cycle memory and inst_ready=1.
//  Redirect (redirect_valid=1), applied at the clock edge and overriding all other updates:
//   fetch_pc <= {redirect_pc[XLEN-1:2],2'b0}; all slots freed; pointers reset to 0;
//   drop_cnt <= drop_cnt + unfilled_slots + req_fire - rsp_fire (same-cycle request counted as stale;
//    same-cycle response consumed against the stale set, never written).
//   Fetch from the new PC may be requested the following cycle, subject to credits.
//  Simultaneous alloc, fill and consume in one cycle are legal; occ and pointers update consistently.
//  Full (occ+drop_cnt==DEPTH): imem_req_valid=0. Empty: inst_valid=0. Pointers wrap mod DEPTH.
//  Reset mid-operation: state clears immediately; memory side must also be reset (in-flight responses are not tracked).
// STRUCTURE
//  Shared in defines.v: `REG_BUS, `INST_BUS (31:0), `RESET_PC.
//  Sub-module fetch_queue: DEPTH-slot ring with per-slot {pc, inst, filled}, alloc/fill/read pointers, flush input.
//  Top holds fetch_pc, credit logic, drop_cnt ($clog2(DEPTH+1) bits), redirect handling.
// TESTING
//  1 Reset: rst=0 -> imem_req_valid=0, inst_valid=0; release -> first request addr 0x8000_0000.
//  2 Stream, 1-cycle mem, inst_ready=1: inst_pc 0x8000_0000, _0004, _0008... on consecutive cycles, no bubbles after first.
//  3 Backpressure, inst_ready=0, DEPTH=4: exactly 4 requests fire, then imem_req_valid=0; inst_ready=1 -> resumes at 0x8000_0010.
//  4 Redirect, 3-cycle mem, 3 in flight: redirect_pc=0x8000_1002 -> 3 responses dropped; first inst_pc=0x8000_1000.
//  5 Redirect coincident with req fire and rsp fire: drop_cnt correct; no stale inst emitted; in-flight never exceeds DEPTH.
//  6 Async reset asserted between clock edges mid-stream: inst_valid and imem_req_valid drop immediately; restart at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared defaults and types for the decoupled instruction-fetch front end.
// Imported by the fetch queue and the top level.
package if_prefetch_pkg;

    localparam int              DEF_XLEN     = 64;
    localparam int              DEF_DEPTH    = 4;
    localparam logic [63:0]     DEF_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        RSP_IGNORE = 2'd0,
        RSP_DROP   = 2'd1,
        RSP_FILL   = 2'd2
    } rsp_action_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Bundles the memory request/response, redirect and decode handshakes of the fetch unit.
// master = fetch unit side, slave = memory/decode/branch environment side.
interface if_prefetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_out;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        output inst_out,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        input  inst_out,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/if_prefetch_fetch_queue.sv
// DEPTH-slot ring of {pc, inst, filled}; slots are allocated at request time and filled
// in order by responses, so the head is only presented once its instruction has arrived.
module if_prefetch_fetch_queue
    import if_prefetch_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [31:0]      fill_data,
    input  logic             consume,
    output logic [CNT_W-1:0] occ,
    output logic [CNT_W-1:0] unfilled,
    output logic             head_valid,
    output logic [31:0]      head_inst,
    output logic [XLEN-1:0]  head_pc
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [DEPTH-1:0] filled_next;
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // The three pointers never address the same slot in a way that conflicts:
    // alloc targets a free slot, fill an allocated one, consume only a filled head.
    always_comb begin
        filled_next = filled;
        if (consume) filled_next[rd_ptr]    = 1'b0;
        if (alloc)   filled_next[alloc_ptr] = 1'b0;
        if (fill)    filled_next[fill_ptr]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            unfilled  <= '0;
            filled    <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            unfilled  <= '0;
            filled    <= '0;
        end else begin
            if (alloc)   alloc_ptr <= alloc_ptr + PTR_W'(1);
            if (fill)    fill_ptr  <= fill_ptr + PTR_W'(1);
            if (consume) rd_ptr    <= rd_ptr + PTR_W'(1);
            occ      <= occ + CNT_W'(alloc) - CNT_W'(consume);
            unfilled <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
            filled   <= filled_next;
        end
    end

    // Payload storage needs no reset; the filled bits gate its visibility.
    always_ff @(posedge clk) begin
        if (alloc) pc_mem[alloc_ptr]  <= alloc_pc;
        if (fill)  inst_mem[fill_ptr] <= fill_data;
    end

    assign head_valid = filled[rd_ptr];
    assign head_inst  = inst_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Decoupled fetch front end: sequential prefetch with credit-limited in-flight requests,
// in-order response buffering and redirect flush that discards stale in-flight responses.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input logic          clk,
    input logic          rst,
    if_prefetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] unfilled;
    logic [CNT_W:0]   committed;
    logic             credit;
    logic             req_fire;
    logic             rsp_fire;
    logic             fill;
    logic             consume;
    logic             head_valid;
    rsp_action_t      rsp_action;

    // Slots still owed a response (including stale ones) count against the credit pool.
    assign committed = {1'b0, occ} + {1'b0, drop_cnt};
    assign credit    = committed < (CNT_W + 1)'(DEPTH);

    assign bus.imem_req_valid = rst && credit;
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // Stale responses are retired before any live slot is filled; a response with
    // nothing outstanding is ignored.
    always_comb begin
        rsp_action = RSP_IGNORE;
        if (bus.imem_rsp_valid) begin
            if (drop_cnt != '0) begin
                rsp_action = RSP_DROP;
            end else if (unfilled != '0) begin
                rsp_action = RSP_FILL;
            end
        end
    end

    assign rsp_fire       = (rsp_action != RSP_IGNORE);
    assign fill           = (rsp_action == RSP_FILL) && !bus.redirect_valid;
    assign bus.inst_valid = head_valid && !bus.redirect_valid;
    assign consume        = bus.inst_valid && bus.inst_ready;

    // On redirect every unfilled slot and any same-cycle request becomes stale,
    // while a same-cycle response retires one of them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & ~XLEN'(3);
            drop_cnt <= drop_cnt + unfilled + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (rsp_action == RSP_DROP) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    if_prefetch_fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc),
        .fill       (fill),
        .fill_data  (bus.imem_rsp_data),
        .consume    (consume),
        .occ        (occ),
        .unfilled   (unfilled),
        .head_valid (head_valid),
        .head_inst  (bus.inst_out),
        .head_pc    (bus.inst_pc)
    );

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: a variable-latency in-order memory model, an expected
// instruction stream derived from the PC sequence rules, and a decoupled monitor.
`timescale 1ns/1ps
module tb_if_prefetch;

    localparam int          XLEN     = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0]     addr;
        longint unsigned due;
    } mem_req_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    if_prefetch_if #(.XLEN(XLEN)) bus ();

    if_prefetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_req_t        mem_q [$];
    exp_t            exp_q [$];
    longint unsigned cyc = 0;
    longint unsigned last_due = 0;
    int              lat_min = 1;
    int              lat_max = 1;
    int              compared = 0;
    int              mismatched = 0;
    int              consume_cnt = 0;
    int              req_fire_cnt = 0;
    logic [63:0]     exp_req_addr = RESET_PC;
    logic [63:0]     exp_next_pc = RESET_PC;
    logic [63:0]     last_req_addr = '0;
    logic [63:0]     last_inst_pc = '0;

    // Memory image: every word is a scrambled function of its address.
    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return addr[31:0] ^ (addr[63:32] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic topUp();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{exp_next_pc, mem_word(exp_next_pc)});
            exp_next_pc = exp_next_pc + 64'd4;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        topUp();
    endtask

    task automatic applyStimulus(input bit redir, input logic [63:0] pc, input bit req_rdy, input bit i_rdy);
        bus.imem_req_ready = req_rdy;
        bus.inst_ready     = i_rdy;
        bus.redirect_pc    = pc;
        if (redir) begin
            bus.redirect_valid = 1'b1;
            exp_q.delete();
            exp_next_pc = {pc[63:2], 2'b00};
            topUp();
        end
    endtask

    task automatic resetDut();
        rst = 1'b0;
        #1;
        checkOutput("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        checkOutput("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        mem_q.delete();
        exp_q.delete();
        last_due     = cyc;
        exp_req_addr = RESET_PC;
        exp_next_pc  = RESET_PC;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("post_rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
        checkOutput("post_rst_req_addr", bus.imem_req_addr, RESET_PC);
    endtask

    // Memory model: in-order responses, each at least one cycle after its request.
    always @(negedge clk) begin
        longint unsigned due;
        cyc = cyc + 1;
        if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #2;
        if (rst) begin
            if (bus.imem_rsp_valid) begin
                assert (mem_q.size() > 0);
                void'(mem_q.pop_front());
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                due = cyc + longint'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{bus.imem_req_addr, due});
            end
        end
    end

    // Monitor: checks request addresses, in-flight bound and the consumed stream.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst) begin
            if (bus.redirect_valid) begin
                checkOutput("inst_valid_in_redirect", 64'(bus.inst_valid), 64'd0);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                req_fire_cnt++;
                last_req_addr = bus.imem_req_addr;
                checkOutput("req_addr", bus.imem_req_addr, exp_req_addr);
                checkOutput("inflight_le_depth", 64'(mem_q.size() <= DEPTH), 64'd1);
                exp_req_addr = exp_req_addr + 64'd4;
            end
            if (bus.redirect_valid) begin
                exp_req_addr = {bus.redirect_pc[63:2], 2'b00};
            end
            if (bus.inst_valid && bus.inst_ready) begin
                consume_cnt++;
                last_inst_pc = bus.inst_pc;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_inst: got pc 0x%0h, expected none", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("inst_pc", bus.inst_pc, e.pc);
                    checkOutput("inst_out", 64'(bus.inst_out), 64'(e.inst));
                end
            end
        end
    end

    initial begin
        logic [63:0] pc;
        bit          rr;
        bit          ir;
        bit          redir;
        int          c0;
        int          f0;
        bit          hit;

        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #1 rst = 1'b0;

        // Reset and sustained streaming with a 1-cycle memory.
        $display("[TB] reset and streaming");
        tick();
        applyStimulus(0, 64'd0, 1, 1);
        resetDut();
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            applyStimulus(0, 64'd0, 1, 1);
            hit = (consume_cnt > 0);
        end
        checkOutput("stream_started", 64'(hit), 64'd1);
        c0 = consume_cnt;
        repeat (20) begin
            tick();
            applyStimulus(0, 64'd0, 1, 1);
        end
        checkOutput("stream_no_bubbles", 64'(consume_cnt - c0), 64'd20);

        // Backpressure: only DEPTH requests may be outstanding in the buffer.
        $display("[TB] backpressure");
        tick();
        applyStimulus(0, 64'd0, 1, 0);
        resetDut();
        f0 = req_fire_cnt;
        repeat (12) begin
            tick();
            applyStimulus(0, 64'd0, 1, 0);
        end
        checkOutput("bp_fire_count", 64'(req_fire_cnt - f0), 64'(DEPTH));
        checkOutput("bp_req_valid", 64'(bus.imem_req_valid), 64'd0);
        f0 = req_fire_cnt;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick();
            applyStimulus(0, 64'd0, 1, 1);
            hit = (req_fire_cnt > f0);
        end
        checkOutput("bp_resume_fired", 64'(hit), 64'd1);
        checkOutput("bp_resume_addr", last_req_addr, 64'h0000_0000_8000_0010);

        // Redirect with three requests in flight on a 3-cycle memory.
        $display("[TB] redirect with requests in flight");
        lat_min = 3;
        lat_max = 3;
        tick();
        applyStimulus(0, 64'd0, 1, 1);
        resetDut();
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (mem_q.size() == 3) begin
                applyStimulus(1, 64'h0000_0000_8000_1002, 1, 1);
                hit = 1;
            end else begin
                applyStimulus(0, 64'd0, 1, 1);
            end
        end
        checkOutput("redirect_issued", 64'(hit), 64'd1);
        c0 = consume_cnt;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            applyStimulus(0, 64'd0, 1, 1);
            hit = (consume_cnt > c0);
        end
        checkOutput("redirect_consumed", 64'(hit), 64'd1);
        checkOutput("redirect_first_pc", last_inst_pc, 64'h0000_0000_8000_1000);

        // Randomised traffic with coincident redirect/request/response events.
        $display("[TB] random traffic");
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            tick();
            rr = ($urandom_range(3, 0) != 0);
            ir = ($urandom_range(3, 0) != 0);
            pc = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) pc[63:8] = '1;
            redir = ($urandom_range(15, 0) == 0);
            if (rr && bus.imem_req_valid && bus.imem_rsp_valid && $urandom_range(3, 0) == 0) redir = 1;
            applyStimulus(redir, pc, rr, ir);
        end

        // Asynchronous reset between edges while streaming.
        $display("[TB] async reset mid-stream");
        repeat (10) begin
            tick();
            applyStimulus(0, 64'd0, 1, 1);
        end
        tick();
        resetDut();
        c0 = consume_cnt;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            applyStimulus(0, 64'd0, 1, 1);
            hit = (consume_cnt > c0);
        end
        checkOutput("restart_consumed", 64'(hit), 64'd1);
        checkOutput("restart_first_pc", last_inst_pc, RESET_PC);
        repeat (10) begin
            tick();
            applyStimulus(0, 64'd0, 1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
